// File: rtl/uart_send_pkg.sv
// Shared UART definitions: line-state encoding and bit-period derivation,
// common to the transmitter and the matching receiver.
package uart_send_pkg;

  // Frame phase of the serial line, 2-bit encoding shared with uart_recv
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SEND  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Data bits per frame (8N1)
  localparam int DATA_BITS = 8;

  // Clock cycles per bit period; integer division, must come out >= 2
  function automatic int calc_cyc_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the UART transmitter. The head entry is read
// combinationally so the FSM can load it into its shift register on the same
// cycle it pops. Writes while full are dropped, even if a pop happens then.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CNT_FULL);
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr_reg];

  // Storage write; no reset needed, occupancy is tracked by the count
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_send.sv
// UART transmitter, 8N1, LSB first. Bytes are queued through wr_en/wr_data
// and serialised on dout; queued frames follow each other with no idle gap.
module uart_send
  import uart_send_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       busy,
  output logic       done,
  output logic       dout
);

  localparam int CYC_BIT = calc_cyc_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W   = (CYC_BIT > 1) ? $clog2(CYC_BIT) : 1;
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(CYC_BIT - 1);
  // done is registered, so it is scheduled one cycle ahead of the last stop cycle
  localparam logic [CNT_W-1:0] CYC_PRE  = CNT_W'(CYC_BIT - 2);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  uart_state_t      state_reg;
  logic [CNT_W-1:0] cyc_cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       data_reg;
  logic             dout_reg;
  logic             done_reg;

  logic             fifo_empty;
  logic [7:0]       fifo_head;
  logic             pop;
  logic             bit_end;

  assign bit_end = (cyc_cnt_reg == CYC_LAST);
  // Pop when idle or at the very end of a stop bit, so frames chain directly
  assign pop  = !fifo_empty &&
                ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && bit_end));
  assign busy = (state_reg != ST_IDLE) || !fifo_empty;
  assign dout = dout_reg;
  assign done = done_reg;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .din   (wr_data),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (full),
    .empty (fifo_empty)
  );

  // Frame sequencer: baud timing, bit shifting and registered line/done outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cyc_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      data_reg    <= '0;
      dout_reg    <= 1'b1;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          dout_reg    <= 1'b1;
          cyc_cnt_reg <= '0;
          if (!fifo_empty) begin
            data_reg  <= fifo_head;
            dout_reg  <= 1'b0;
            state_reg <= ST_START;
          end
        end

        ST_START: begin
          if (bit_end) begin
            cyc_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            dout_reg    <= data_reg[0];
            data_reg    <= {1'b0, data_reg[7:1]};
            state_reg   <= ST_SEND;
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + CNT_W'(1);
          end
        end

        ST_SEND: begin
          if (bit_end) begin
            cyc_cnt_reg <= '0;
            if (bit_cnt_reg == BIT_LAST) begin
              dout_reg  <= 1'b1;
              state_reg <= ST_STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              dout_reg    <= data_reg[0];
              data_reg    <= {1'b0, data_reg[7:1]};
            end
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (cyc_cnt_reg == CYC_PRE) begin
            done_reg <= 1'b1;
          end
          if (bit_end) begin
            cyc_cnt_reg <= '0;
            if (!fifo_empty) begin
              data_reg  <= fifo_head;
              dout_reg  <= 1'b0;
              state_reg <= ST_START;
            end else begin
              dout_reg  <= 1'b1;
              state_reg <= ST_IDLE;
            end
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + CNT_W'(1);
          end
        end

        default: begin
          dout_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_send.sv
// Directed testbench for uart_send with CYC_BIT = 10 (frame = 100 cycles).
// A line decoder samples dout mid-bit and collects the received bytes.
module tb_uart_send;

  localparam int CLK_FREQ   = 100;
  localparam int BAUD_RATE  = 10;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic       busy;
  logic       done;
  logic       dout;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_total = 0;

  logic [7:0] rx_q[$];
  int         rx_start[$];

  always #5 clk = ~clk;

  uart_send #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .busy    (busy),
    .done    (done),
    .dout    (dout)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) done_total++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line decoder: start seen at negedge of first low cycle, sample mid-bit
  initial begin : line_monitor
    logic [7:0] b;
    logic       abort;
    logic       st_ok;
    logic       sp_ok;
    int         t0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && dout === 1'b0) begin
        t0 = cyc; abort = 1'b0; b = 8'h00; st_ok = 1'b0; sp_ok = 1'b0;
        for (int k = 0; k < 96; k++) begin
          if (k > 0) @(negedge clk);
          if (rst !== 1'b0) abort = 1'b1;
          if (k == 5) st_ok = (dout === 1'b0);
          if (k >= 15 && k <= 85 && (k % 10) == 5) b[(k - 15) / 10] = dout;
          if (k == 95) sp_ok = (dout === 1'b1);
        end
        if (!abort) begin
          check("start_bit", 32'(st_ok), 32'd1);
          check("stop_bit", 32'(sp_ok), 32'd1);
          rx_q.push_back(b);
          rx_start.push_back(t0);
          $display("rx byte %02h at cycle %0d", b, t0);
        end
      end
    end
  end

  // Push one byte over a single clock edge; called and returns at a negedge
  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
    wr_data = ~d;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n = 0;
    while (busy !== 1'b0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy === 1'b0), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    while (done !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done === 1'b1), 32'd1);
  endtask

  task automatic check_rx(input string tag, input logic [7:0] exp_q[$], input logic gaps);
    check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
      if (gaps && i > 0 && i < rx_start.size())
        check($sformatf("%s_gap%0d", tag, i), 32'(rx_start[i] - rx_start[i-1]), 32'(FRAME));
    end
  endtask

  task automatic idle_line(input string tag, input int ncyc);
    logic low_seen = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (dout !== 1'b1) low_seen = 1'b1;
    end
    check(tag, 32'(low_seen), 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [9:0] exp_frame;
    logic       line_v[FRAME];
    logic       done_v[FRAME];
    logic [7:0] exp_q[$];
    int         cnt;
    int         d0;

    // 1: reset held three cycles
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(dout), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    idle_line("idle_line", 20);
    check("idle_busy", 32'(busy), 32'd0);

    // 2: single byte 0x55, exact line waveform and done timing
    rx_q.delete(); rx_start.delete();
    write_byte(8'h55);
    check("t2_dout_lat1", 32'(dout), 32'd1);
    check("t2_busy", 32'(busy), 32'd1);
    @(negedge clk);
    for (int i = 0; i < FRAME; i++) begin
      line_v[i] = dout;
      done_v[i] = done;
      @(negedge clk);
    end
    check("t2_busy_after", 32'(busy), 32'd0);
    check("t2_dout_after", 32'(dout), 32'd1);
    exp_frame = {1'b1, 8'h55, 1'b0};
    for (int b = 0; b < 10; b++) begin
      cnt = 0;
      for (int c = 0; c < 10; c++) if (line_v[b*10 + c] === exp_frame[b]) cnt++;
      check($sformatf("t2_bit%0d_cycles", b), 32'(cnt), 32'd10);
    end
    cnt = 0;
    for (int i = 0; i < FRAME; i++) if (done_v[i] === 1'b1) cnt++;
    check("t2_done_count", 32'(cnt), 32'd1);
    check("t2_done_last", 32'(done_v[FRAME-1]), 32'd1);
    exp_q = '{8'h55};
    check_rx("t2_rx", exp_q, 1'b0);

    // 3: four bytes back-to-back
    rx_q.delete(); rx_start.delete();
    d0 = done_total;
    write_byte(8'hA3);
    write_byte(8'h0F);
    write_byte(8'hFF);
    write_byte(8'h00);
    wait_idle("t3_idle", 600);
    exp_q = '{8'hA3, 8'h0F, 8'hFF, 8'h00};
    check_rx("t3_rx", exp_q, 1'b1);
    check("t3_done_pulses", 32'(done_total - d0), 32'd4);

    // 4: fill FIFO, drop writes while full (also on the pop cycle)
    rx_q.delete(); rx_start.delete();
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    write_byte(8'h44);
    write_byte(8'h55);
    check("t4_full_set", 32'(full), 32'd1);
    write_byte(8'h77);
    check("t4_full_hold", 32'(full), 32'd1);
    wait_done("t4_wait_done", 200);
    check("t4_full_at_pop", 32'(full), 32'd1);
    write_byte(8'h66);
    check("t4_full_clear", 32'(full), 32'd0);
    wait_idle("t4_idle", 700);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    check_rx("t4_rx", exp_q, 1'b1);

    // 5: push coinciding with the stop-end pop while one byte is queued
    rx_q.delete(); rx_start.delete();
    write_byte(8'h81);
    write_byte(8'h82);
    wait_done("t5_wait_done", 200);
    write_byte(8'h83);
    check("t5_full", 32'(full), 32'd0);
    check("t5_busy", 32'(busy), 32'd1);
    wait_idle("t5_idle", 400);
    exp_q = '{8'h81, 8'h82, 8'h83};
    check_rx("t5_rx", exp_q, 1'b1);

    // 6: reset in the middle of a data bit, with a byte still queued
    rx_q.delete(); rx_start.delete();
    d0 = done_total;
    write_byte(8'hC4);
    write_byte(8'h99);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_dout", 32'(dout), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_full", 32'(full), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_line("t6_idle_line", 60);
    check("t6_no_done", 32'(done_total - d0), 32'd0);
    write_byte(8'h3C);
    wait_idle("t6_idle", 200);
    exp_q = '{8'h3C};
    check_rx("t6_rx", exp_q, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
